// File: rtl/game_over_overlay_pkg.sv
// Shared definitions for the game-over LED compositor: FSM state encoding,
// row source selection and the row-bus packing helper.
package game_over_overlay_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_FLASH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_LIVE = 2'd0,
    SRC_SNAP = 2'd1,
    SRC_OVER = 2'd2
  } row_src_e;

  // Row r of a packed row bus occupies bits [r*row_width +: row_width].
  function automatic int unsigned row_lsb(input int unsigned r, input int unsigned row_width);
    return r * row_width;
  endfunction

endpackage

// File: rtl/game_over_overlay_blink_timer.sv
// Flash timer: divides the clock into half-periods and counts phase toggles
// until the configured number of toggles has elapsed.
module blink_timer #(
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic clock,
  input  logic aclr,
  input  logic run,
  input  logic clear,
  output logic tick,
  output logic phase,
  output logic done
);

  localparam int unsigned DIV_W = $clog2(BLINK_DIV);
  localparam int unsigned TOG_W = $clog2(BLINK_COUNT + 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [TOG_W-1:0] tog_cnt_q, tog_cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    tick      = run && (div_cnt_q == DIV_W'(BLINK_DIV - 1));
    done      = tick && (tog_cnt_q == TOG_W'(BLINK_COUNT - 1));
    div_cnt_d = div_cnt_q;
    tog_cnt_d = tog_cnt_q;
    phase_d   = phase_q;
    if (clear) begin
      div_cnt_d = '0;
      tog_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (run) begin
      if (tick) begin
        div_cnt_d = '0;
        tog_cnt_d = tog_cnt_q + TOG_W'(1);
        // The final toggle parks the phase on the game-over image.
        phase_d   = done ? 1'b1 : ~phase_q;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      div_cnt_q <= '0;
      tog_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tog_cnt_q <= tog_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/game_over_overlay.sv
// LED-row compositor: passes play-field rows through, freezes and flashes
// them against a game-over image on collision, then holds the image until restart.
module game_over_overlay
  import game_over_overlay_pkg::*;
#(
  parameter int unsigned NUM_ROWS    = 4,
  parameter int unsigned ROW_WIDTH   = 6,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic                          clock,
  input  logic                          aclr,
  input  logic [NUM_ROWS*ROW_WIDTH-1:0] rows_in,
  input  logic [NUM_ROWS*ROW_WIDTH-1:0] over_pattern,
  input  logic                          collision,
  input  logic                          restart,
  output logic [NUM_ROWS*ROW_WIDTH-1:0] rows_out,
  output logic                          game_over,
  output logic                          flash_phase
);

  localparam int unsigned BUS_W = NUM_ROWS * ROW_WIDTH;

  state_e            state_q, state_d;
  row_src_e          row_src;
  logic [BUS_W-1:0]  snap_q, snap_d;
  logic [BUS_W-1:0]  rows_out_q, rows_out_d;
  logic              game_over_q, game_over_d;
  logic              t_run, t_clear, t_tick, t_phase, t_done;
  logic              phase_nxt;

  // Timer controls depend only on registered state and restart, keeping
  // the tick/done feedback into the FSM free of combinational loops.
  assign t_run   = (state_q == ST_FLASH) && !restart;
  assign t_clear = (state_q == ST_PLAY) || restart;

  blink_timer #(
    .BLINK_DIV   (BLINK_DIV),
    .BLINK_COUNT (BLINK_COUNT)
  ) u_blink_timer (
    .clock (clock),
    .aclr  (aclr),
    .run   (t_run),
    .clear (t_clear),
    .tick  (t_tick),
    .phase (t_phase),
    .done  (t_done)
  );

  assign phase_nxt = t_done ? 1'b1 : (t_phase ^ t_tick);

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    game_over_d = game_over_q;
    row_src     = SRC_LIVE;
    unique case (state_q)
      ST_PLAY: begin
        if (collision) begin
          state_d     = ST_FLASH;
          snap_d      = rows_in;
          game_over_d = 1'b1;
        end
      end
      ST_FLASH: begin
        if (restart) begin
          state_d     = ST_PLAY;
          game_over_d = 1'b0;
        end else begin
          row_src = phase_nxt ? SRC_OVER : SRC_SNAP;
          if (t_done) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (restart) begin
          state_d     = ST_PLAY;
          game_over_d = 1'b0;
        end else begin
          row_src = SRC_OVER;
        end
      end
      default: begin
        state_d     = ST_PLAY;
        game_over_d = 1'b0;
      end
    endcase
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    localparam int unsigned LSB = row_lsb(r, ROW_WIDTH);
    assign rows_out_d[LSB +: ROW_WIDTH] =
      (row_src == SRC_OVER) ? over_pattern[LSB +: ROW_WIDTH] :
      (row_src == SRC_SNAP) ? snap_q[LSB +: ROW_WIDTH] :
                              rows_in[LSB +: ROW_WIDTH];
  end

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      state_q     <= ST_PLAY;
      snap_q      <= '0;
      rows_out_q  <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      rows_out_q  <= rows_out_d;
      game_over_q <= game_over_d;
    end
  end

  assign rows_out    = rows_out_q;
  assign game_over   = game_over_q;
  assign flash_phase = t_phase;

endmodule

// File: tb/tb_game_over_overlay.sv
// Directed bench for game_over_overlay with a cycle-age reference model and
// per-cycle output comparison, plus literal checkpoints.
module tb_game_over_overlay;

  localparam int unsigned NR  = 4;
  localparam int unsigned RW  = 6;
  localparam int unsigned DIV = 4;
  localparam int unsigned CNT = 3;
  localparam int unsigned BW  = NR * RW;

  logic          clock = 1'b0;
  logic          aclr  = 1'b1;
  logic [BW-1:0] rows_in = '0;
  logic [BW-1:0] over_pattern = '0;
  logic          collision = 1'b0;
  logic          restart = 1'b0;
  logic [BW-1:0] rows_out;
  logic          game_over;
  logic          flash_phase;

  int total = 0;
  int bad   = 0;

  game_over_overlay #(
    .NUM_ROWS    (NR),
    .ROW_WIDTH   (RW),
    .BLINK_DIV   (DIV),
    .BLINK_COUNT (CNT)
  ) dut (
    .clock        (clock),
    .aclr         (aclr),
    .rows_in      (rows_in),
    .over_pattern (over_pattern),
    .collision    (collision),
    .restart      (restart),
    .rows_out     (rows_out),
    .game_over    (game_over),
    .flash_phase  (flash_phase)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game-over episode tracked by its age in edges since the collision.
  bit            m_over;
  int            m_age;
  logic [BW-1:0] m_snap, e_rows;
  logic          e_go, e_ph;

  always @(posedge clock or negedge aclr) begin
    if (!aclr) begin
      m_over = 0; m_age = 0; m_snap = '0;
      e_rows = '0; e_go = 0; e_ph = 0;
    end else if (!m_over) begin
      e_rows = rows_in;
      if (collision) begin
        m_over = 1; m_age = 0; m_snap = rows_in;
        e_go = 1; e_ph = 0;
      end
    end else if (restart) begin
      m_over = 0; e_go = 0; e_ph = 0; e_rows = rows_in;
    end else begin
      int halves;
      m_age++;
      halves = m_age / DIV;
      if (halves >= CNT) e_ph = 1;
      else e_ph = halves[0];
      e_rows = e_ph ? over_pattern : m_snap;
    end
  end

  bit cmp_en = 0;
  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_rows", rows_out, e_rows);
      check("model_go", {23'd0, game_over}, {23'd0, e_go});
      check("model_phase", {23'd0, flash_phase}, {23'd0, e_ph});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    // 1: async reset with no clock edge, then pass-through
    #1 aclr = 1'b0;
    #1;
    check("reset_rows", rows_out, 24'h000000);
    check("reset_go", {23'd0, game_over}, 24'd0);
    cmp_en = 1;
    #10 aclr = 1'b1;
    rows_in = 24'h123456;
    step(1);
    check("pass_through", rows_out, 24'h123456);

    // 2/3: collision flash with freeze
    rows_in = 24'hABCDEF; over_pattern = 24'hFFF041; collision = 1'b1;
    step(1);
    collision = 1'b0;
    check("col_frame", rows_out, 24'hABCDEF);
    check("col_go", {23'd0, game_over}, 24'd1);
    rows_in = 24'h000000;
    step(3);
    check("freeze_snap", rows_out, 24'hABCDEF);
    step(1);
    check("flash_over", rows_out, 24'hFFF041);
    check("flash_phase1", {23'd0, flash_phase}, 24'd1);
    step(4);
    check("flash_snap2", rows_out, 24'hABCDEF);
    step(3);
    check("flash_snap2_end", rows_out, 24'hABCDEF);
    step(1);
    check("hold_entry", rows_out, 24'hFFF041);
    check("hold_phase", {23'd0, flash_phase}, 24'd1);
    step(5);
    check("hold_steady", rows_out, 24'hFFF041);
    over_pattern = 24'h0A0A0A;
    step(1);
    check("hold_track", rows_out, 24'h0A0A0A);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    check("hold_col_ignored", {23'd0, game_over}, 24'd1);

    // 4: restart in HOLD, then in PLAY
    rows_in = 24'h111111; restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_go", {23'd0, game_over}, 24'd0);
    check("restart_rows", rows_out, 24'h111111);
    rows_in = 24'h222222; restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_play_rows", rows_out, 24'h222222);
    check("restart_play_go", {23'd0, game_over}, 24'd0);

    // 5: simultaneous collision and restart
    rows_in = 24'h333333; collision = 1'b1; restart = 1'b1;
    step(1);
    collision = 1'b0; restart = 1'b0;
    check("sim_play_go", {23'd0, game_over}, 24'd1);
    step(13);
    check("sim_hold_phase", {23'd0, flash_phase}, 24'd1);
    rows_in = 24'h444444; collision = 1'b1; restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("sim_hold_go", {23'd0, game_over}, 24'd0);
    check("sim_hold_rows", rows_out, 24'h444444);
    step(1);
    collision = 1'b0;
    check("held_col_reenter", {23'd0, game_over}, 24'd1);
    check("held_col_phase", {23'd0, flash_phase}, 24'd0);

    // 6: reset mid-FLASH
    step(2);
    #1 aclr = 1'b0;
    #1;
    check("midreset_rows", rows_out, 24'h000000);
    check("midreset_go", {23'd0, game_over}, 24'd0);
    #2 aclr = 1'b1;
    rows_in = 24'h555555;
    step(1);
    check("post_reset_rows", rows_out, 24'h555555);
    step(8);
    check("post_reset_go", {23'd0, game_over}, 24'd0);
    check("post_reset_phase", {23'd0, flash_phase}, 24'd0);
    check("post_reset_steady", rows_out, 24'h555555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
